// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 PRGA decrypt block.
package rc4_pkg;

  typedef logic [7:0] byte_t;

  // One state per memory access or write of the per-byte loop.
  typedef enum logic [3:0] {
    IDLE,
    LEN_A,
    LEN_D,
    SI_A,
    SI_D,
    SJ_A,
    SJ_D,
    WR_I,
    WR_J,
    PAD_A,
    PAD_D,
    WR_PT,
    DONE
  } prga_state_e;

  localparam byte_t ASCII_MIN = 8'h20;
  localparam byte_t ASCII_MAX = 8'h7E;
  localparam int unsigned S_DEPTH = 256;

endpackage

// File: rtl/rc4_ascii_chk.sv
// Sticky printable-ASCII checker over the plaintext bytes of one message.
// Only instantiated when RC4_PRGA_ASCII_CHK_EN is defined.
module rc4_ascii_chk
  import rc4_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_start,
  input  logic  i_wr,
  input  byte_t i_data,
  output logic  o_ok
);

  logic r_ok;

  // Re-arm on every accepted start, drop on any non-printable plaintext byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ok <= 1'b1;
    end else if (i_start) begin
      r_ok <= 1'b1;
    end else if (i_wr && ((i_data < ASCII_MIN) || (i_data > ASCII_MAX))) begin
      r_ok <= 1'b0;
    end
  end

  assign o_ok = r_ok;

endmodule

// File: rtl/rc4_prga.sv
// RC4 pseudo-random generation + decrypt: reads the KSA-permuted S, keeps
// swapping it, and writes PT[k] = pad ^ CT[k] for a length-prefixed CT.
// Nine cycles per byte; S and CT have one-cycle synchronous read latency.
// Optional: RC4_PRGA_ASCII_CHK_EN adds o_pt_ascii_ok (printable plaintext flag).
module rc4_prga
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_MAX = 255
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_en,
  output logic  o_rdy,
  output byte_t o_s_addr,
  input  byte_t i_s_rddata,
  output byte_t o_s_wrdata,
  output logic  o_s_wren,
  output byte_t o_ct_addr,
  input  byte_t i_ct_rddata,
  output byte_t o_pt_addr,
  output byte_t o_pt_wrdata,
  output logic  o_pt_wren
`ifdef RC4_PRGA_ASCII_CHK_EN
  ,
  output logic  o_pt_ascii_ok
`endif
);

  // Message length can never exceed what an 8-bit index into S can address.
  localparam int unsigned LEN_CAP = (MSG_MAX < S_DEPTH) ? MSG_MAX : S_DEPTH - 1;

  prga_state_e r_state, w_state_nxt;
  byte_t r_i, r_j, r_k, r_len, r_si, r_sj, r_pad, r_ct;
  byte_t w_len;

  // Clamp the length byte read from CT[0].
  assign w_len = ({1'b0, i_ct_rddata} > 9'(LEN_CAP)) ? 8'(LEN_CAP) : i_ct_rddata;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: one state per cycle, loop SI_A..WR_PT once per byte.
  // NOTE: default assignment first so no path leaves w_state_nxt unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (i_en) w_state_nxt = LEN_A;
      LEN_A:   w_state_nxt = LEN_D;
      LEN_D:   w_state_nxt = (w_len != 8'd0) ? SI_A : DONE;
      SI_A:    w_state_nxt = SI_D;
      SI_D:    w_state_nxt = SJ_A;
      SJ_A:    w_state_nxt = SJ_D;
      SJ_D:    w_state_nxt = WR_I;
      WR_I:    w_state_nxt = WR_J;
      WR_J:    w_state_nxt = PAD_A;
      PAD_A:   w_state_nxt = PAD_D;
      PAD_D:   w_state_nxt = WR_PT;
      WR_PT:   w_state_nxt = (r_k == r_len) ? DONE : SI_A;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath registers: indices, length, and latched memory read data.
  // NOTE: S, CT and PT live outside this block and are never cleared on
  // reset; only the control and datapath flops below are.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
      r_len <= '0;
      r_si  <= '0;
      r_sj  <= '0;
      r_pad <= '0;
      r_ct  <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (i_en) begin
          r_i <= '0;
          r_j <= '0;
          r_k <= '0;
        end
        LEN_D: begin
          r_len <= w_len;
          r_k   <= 8'd1;
        end
        SI_A: r_i <= r_i + 8'd1;
        SI_D: begin
          r_si <= i_s_rddata;
          r_j  <= r_j + i_s_rddata;
        end
        SJ_D: r_sj <= i_s_rddata;
        PAD_D: begin
          r_pad <= i_s_rddata;
          r_ct  <= i_ct_rddata;
        end
        WR_PT: if (r_k != r_len) r_k <= r_k + 8'd1;
        default: ;
      endcase
    end
  end

  // Memory-port outputs decoded from the current state; idle drives all zero.
  // Swap writes use the latched si/sj, so i==j and the pad index stay correct.
  always_comb begin
    o_rdy       = (r_state == IDLE);
    o_s_addr    = '0;
    o_s_wrdata  = '0;
    o_s_wren    = 1'b0;
    o_ct_addr   = '0;
    o_pt_addr   = '0;
    o_pt_wrdata = '0;
    o_pt_wren   = 1'b0;
    unique case (r_state)
      LEN_D: begin
        o_pt_wrdata = w_len;
        o_pt_wren   = 1'b1;
      end
      SI_A:  o_s_addr = r_i + 8'd1;
      SJ_A:  o_s_addr = r_j;
      WR_I: begin
        o_s_addr   = r_i;
        o_s_wrdata = r_sj;
        o_s_wren   = 1'b1;
      end
      WR_J: begin
        o_s_addr   = r_j;
        o_s_wrdata = r_si;
        o_s_wren   = 1'b1;
      end
      PAD_A: begin
        o_s_addr  = r_si + r_sj;
        o_ct_addr = r_k;
      end
      WR_PT: begin
        o_pt_addr   = r_k;
        o_pt_wrdata = r_pad ^ r_ct;
        o_pt_wren   = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef RC4_PRGA_ASCII_CHK_EN
  logic  w_chk_start, w_chk_wr;
  byte_t w_chk_data;

  assign w_chk_start = (r_state == IDLE) && i_en;
  assign w_chk_wr    = (r_state == WR_PT);
  assign w_chk_data  = r_pad ^ r_ct;

  rc4_ascii_chk u_ascii_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_chk_start),
    .i_wr    (w_chk_wr),
    .i_data  (w_chk_data),
    .o_ok    (o_pt_ascii_ok)
  );
`endif

endmodule

// File: tb/tb_rc4_prga.sv
// Self-checking bench for rc4_prga: S/CT/PT memory models, a plain RC4
// reference, directed literal cases and randomized messages.
module tb_rc4_prga;
  import rc4_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  en = 1'b0;
  logic  rdy, s_wren, pt_wren;
  byte_t s_addr, s_wrdata, ct_addr, pt_addr, pt_wrdata;
  byte_t s_rddata, ct_rddata;
`ifdef RC4_PRGA_ASCII_CHK_EN
  logic  pt_ascii_ok;
`endif

  always #5 clk = ~clk;

  rc4_prga dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (en),
    .o_rdy       (rdy),
    .o_s_addr    (s_addr),
    .i_s_rddata  (s_rddata),
    .o_s_wrdata  (s_wrdata),
    .o_s_wren    (s_wren),
    .o_ct_addr   (ct_addr),
    .i_ct_rddata (ct_rddata),
    .o_pt_addr   (pt_addr),
    .o_pt_wrdata (pt_wrdata),
    .o_pt_wren   (pt_wren)
`ifdef RC4_PRGA_ASCII_CHK_EN
    ,
    .o_pt_ascii_ok (pt_ascii_ok)
`endif
  );

  // Memories with 1-cycle synchronous read; bulk preload through load_req.
  byte_t s_mem [256];
  byte_t pt_mem [256];
  byte_t ct_mem [256];
  byte_t s_init [256];
  byte_t pt_init [256];
  bit    load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      s_mem  <= s_init;
      pt_mem <= pt_init;
    end else begin
      if (s_wren)  s_mem[s_addr]   <= s_wrdata;
      if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
    end
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Reference model: textbook RC4 PRGA over a copy of S.
  typedef struct {
    byte_t a;
    byte_t d;
  } wr_t;

  byte_t m_s [256];
  byte_t m_pt [256];
  bit    m_ok;
  wr_t   exp_q[$];

  task automatic model_run();
    byte_t len, i, j, t, tmp;
    len = ct_mem[0];
    m_pt[0] = len;
    exp_q.push_back('{8'd0, len});
    m_ok = 1'b1;
    i = 8'd0;
    j = 8'd0;
    for (int k = 1; k <= int'(len); k++) begin
      i = i + 8'd1;
      j = j + m_s[i];
      tmp = m_s[i];
      m_s[i] = m_s[j];
      m_s[j] = tmp;
      t = m_s[i] + m_s[j];
      m_pt[k] = m_s[t] ^ ct_mem[k];
      exp_q.push_back('{byte_t'(k), m_pt[k]});
      if (m_pt[k] < ASCII_MIN || m_pt[k] > ASCII_MAX) m_ok = 1'b0;
    end
  endtask

  // Per-cycle compare of every PT write against the model's write stream.
  logic prev_pt = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pt <= 1'b0;
    end else begin
      if (pt_wren) begin
        check("pt_wren_consec", {31'd0, prev_pt}, 32'd0);
        if (exp_q.size() == 0) begin
          fail_now("pt_write_unexpected");
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("pt_wr_addr", pt_addr, e.a);
          check("pt_wr_data", pt_wrdata, e.d);
        end
      end
      prev_pt <= pt_wren;
    end
  end

  task automatic load_mems();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    m_s  = s_init;
    m_pt = pt_init;
  endtask

  task automatic set_identity();
    for (int x = 0; x < 256; x++) s_init[x] = byte_t'(x);
  endtask

  task automatic set_random_perm();
    set_identity();
    for (int x = 255; x > 0; x--) begin
      int y;
      byte_t tmp;
      y = int'($urandom_range(x, 0));
      tmp = s_init[x];
      s_init[x] = s_init[y];
      s_init[y] = tmp;
    end
  endtask

  task automatic fill_pt(input byte_t v);
    for (int x = 0; x < 256; x++) pt_init[x] = v;
  endtask

  task automatic set_random_ct(input int len);
    ct_mem[0] = byte_t'(len);
    for (int x = 1; x < 256; x++) ct_mem[x] = byte_t'($urandom_range(255, 0));
  endtask

  task automatic launch();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
  endtask

  // Counts rdy-low cycles sampled at negedges until rdy returns.
  task automatic wait_done(input string tag, output int low);
    low = 0;
    while (1) begin
      @(negedge clk);
      if (rdy) break;
      low++;
      if (low > 5000) begin
        fail_now({tag, "_timeout"});
        break;
      end
    end
  endtask

  task automatic compare_mems(input string tag);
    int ds, dp;
    ds = 0;
    dp = 0;
    for (int x = 0; x < 256; x++) begin
      if (s_mem[x] !== m_s[x]) ds++;
      if (pt_mem[x] !== m_pt[x]) dp++;
    end
    check({tag, "_s_diffs"}, ds, 0);
    check({tag, "_pt_diffs"}, dp, 0);
    check({tag, "_q_left"}, exp_q.size(), 0);
`ifdef RC4_PRGA_ASCII_CHK_EN
    check({tag, "_ascii_ok"}, {31'd0, pt_ascii_ok}, {31'd0, m_ok});
`endif
  endtask

  // Full run: preload, model, start, time rdy, compare memories.
  task automatic run_case(input string tag, output int low);
    int len;
    len = int'(ct_mem[0]);
    load_mems();
    model_run();
    launch();
    wait_done(tag, low);
    check({tag, "_rdy_low"}, low, 3 + 9 * len);
    compare_mems(tag);
  endtask

  initial begin
    int low, low2, n, c;

    // Reset state.
    #1;
    check("rst_rdy", {31'd0, rdy}, 32'd1);
    check("rst_s_wren", {31'd0, s_wren}, 32'd0);
    check("rst_pt_wren", {31'd0, pt_wren}, 32'd0);
    check("rst_s_addr", s_addr, 32'd0);
    check("rst_pt_addr", pt_addr, 32'd0);
    check("rst_ct_addr", ct_addr, 32'd0);
`ifdef RC4_PRGA_ASCII_CHK_EN
    check("rst_ascii_ok", {31'd0, pt_ascii_ok}, 32'd1);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Identity S, CT={01,00}.
    set_identity();
    fill_pt(8'h00);
    ct_mem[0] = 8'h01;
    ct_mem[1] = 8'h00;
    run_case("t1", low);
    check("t1_model_pt1", m_pt[1], 32'h02);
    check("t1_pt0", pt_mem[0], 32'h01);
    check("t1_pt1", pt_mem[1], 32'h02);
    check("t1_s1", s_mem[1], 32'h01);
    check("t1_s2", s_mem[2], 32'h02);
    check("t1_low_lit", low, 32'd12);
`ifdef RC4_PRGA_ASCII_CHK_EN
    check("t1_ascii_lit", {31'd0, pt_ascii_ok}, 32'd0);
`endif

    // Identity S, CT={02,00,FF}.
    set_identity();
    ct_mem[0] = 8'h02;
    ct_mem[1] = 8'h00;
    ct_mem[2] = 8'hFF;
    run_case("t2", low);
    check("t2_model_pt2", m_pt[2], 32'hFA);
    check("t2_pt1", pt_mem[1], 32'h02);
    check("t2_pt2", pt_mem[2], 32'hFA);
    check("t2_s2", s_mem[2], 32'h03);
    check("t2_s3", s_mem[3], 32'h02);
    check("t2_low_lit", low, 32'd21);

    // len=0: only PT[0] written.
    set_identity();
    fill_pt(8'hA5);
    ct_mem[0] = 8'h00;
    run_case("t3", low);
    check("t3_pt0", pt_mem[0], 32'h00);
    check("t3_pt1_untouched", pt_mem[1], 32'hA5);
    check("t3_low_lit", low, 32'd3);

    // Printable plaintext: 02 ^ 4A = 'H'.
    set_identity();
    fill_pt(8'h00);
    ct_mem[0] = 8'h01;
    ct_mem[1] = 8'h4A;
    run_case("t4", low);
    check("t4_pt1", pt_mem[1], 32'h48);
`ifdef RC4_PRGA_ASCII_CHK_EN
    check("t4_ascii_lit", {31'd0, pt_ascii_ok}, 32'd1);
`endif

    // Randomized messages over random permutations, then the maximum length.
    for (int r = 0; r < 5; r++) begin
      set_random_perm();
      fill_pt(8'h00);
      set_random_ct(int'($urandom_range(24, 1)));
      run_case($sformatf("rnd%0d", r), low);
    end
    set_random_perm();
    set_random_ct(255);
    run_case("maxlen", low);

    // Reset in WR_I of byte 3 of a len=5 run.
    set_identity();
    fill_pt(8'h00);
    set_random_ct(5);
    load_mems();
    model_run();
    launch();
    n = 0;
    c = 0;
    while (n < 5 && c < 500) begin
      @(negedge clk);
      c++;
      if (s_wren) n++;
    end
    if (n < 5) fail_now("mid_rst_wait");
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdy", {31'd0, rdy}, 32'd1);
    check("mid_rst_s_wren", {31'd0, s_wren}, 32'd0);
    check("mid_rst_pt_wren", {31'd0, pt_wren}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    set_identity();
    set_random_ct(4);
    run_case("after_rst", low);

    // en held high: one run per rdy window, restart only from idle.
    set_random_perm();
    fill_pt(8'h00);
    set_random_ct(3);
    load_mems();
    model_run();
    model_run();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    wait_done("held1", low);
    check("held1_rdy_low", low, 32'd30);
    @(posedge clk);
    #1 en = 1'b0;
    wait_done("held2", low2);
    check("held2_rdy_low", low2, 32'd30);
    @(negedge clk);
    check("held_idle_after", {31'd0, rdy}, 32'd1);
    compare_mems("held");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rc4_prga.md
Name: rc4_prga

Overview:
- Reader/consumer counterpart to the init+KSA writer.
- Once KSA has left the permuted array in on-chip memory S, this block reads S and runs the RC4 pseudo-random generation algorithm (PRGA). It continues swapping S during generation.
- It decrypts a length-prefixed ciphertext memory CT into a plaintext memory PT.
- It sits beside init/ksa under the same top-level arbiter and shares S through an address/data/wren mux.

Parameters:
- MSG_MAX, 255, maximum message length in bytes; CT/PT depth is MSG_MAX+1.

Ports:
- clk  in  1  system clock (CLOCK_50 at top).
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  start request; accepted only when rdy=1.
- rdy  out  1  high when idle and able to accept en.
- s_addr  out  8  S memory address.
- s_rddata  in  8  S read data; 1-cycle synchronous read latency.
- s_wrdata  out  8  S write data.
- s_wren  out  1  S write enable.
- ct_addr  out  8  CT address.
- ct_rddata  in  8  CT read data; 1-cycle latency.
- pt_addr  out  8  PT address.
- pt_wrdata  out  8  PT write data.
- pt_wren  out  1  PT write enable.
- pt_ascii_ok  out  1  present only with RC4_PRGA_ASCII_CHK_EN (see Optional Feature).

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE; rdy=1.
  - s_wren=0, pt_wren=0; all addresses and write data = 0.
  - Internal i, j, k, len = 0.
  - Partially modified S/PT contents are left as-is; nothing is cleaned up.
- Handshake:
  - en is sampled at a rising edge while rdy=1. rdy drops the following cycle.
  - en while busy is ignored and not queued.
  - rdy returns high in the cycle after the final write.
- Algorithm:
  - len = CT[0]; PT[0] = len.
  - For k = 1..len: i=i+1; j=j+S[i]; swap S[i],S[j]; pad=S[(S[i]+S[j])]; PT[k]=pad ^ CT[k].
  - i, j and the pad index are all 8-bit and wrap mod 256 with no saturation.
- FSM states, one cycle each:
  - IDLE: ct_addr=0; on en go to LEN_A.
  - LEN_A: wait for read data.
  - LEN_D: latch len=ct_rddata; pt_addr=0, pt_wrdata=len, pt_wren=1; go to SI_A if len!=0, else go to DONE.
  - SI_A: i<=i+1; s_addr=i+1.
  - SI_D: latch si=s_rddata; j<=j+s_rddata.
  - SJ_A: s_addr=j.
  - SJ_D: latch sj.
  - WR_I: s_addr=i, s_wrdata=sj, s_wren=1.
  - WR_J: s_addr=j, s_wrdata=si, s_wren=1.
  - PAD_A: s_addr=si+sj; ct_addr=k.
  - PAD_D: latch pad and ct byte.
  - WR_PT: pt_addr=k, pt_wrdata=pad^ct, pt_wren=1; then k==len goes to DONE, else k<=k+1 and go to SI_A.
  - DONE: rdy<=1, go to IDLE.
- Timing:
  - Exactly 9 cycles per byte.
  - rdy is low for 3+9*len cycles after the accepting edge.
- Boundary conditions:
  - i==j: swap writes the same value twice. Latched si/sj are used, so the result is correct.
  - The pad index is computed from latched si, sj. Their sum is invariant under the swap.
  - len=0: only PT[0]=0 is written.
  - len>MSG_MAX: clamp to MSG_MAX.
  - Write enables are never high in two consecutive cycles for the same memory, except WR_I→WR_J on S.

Optional Feature:
- Macro: RC4_PRGA_ASCII_CHK_EN.
- Defined:
  - Adds the pt_ascii_ok output, used by the future key-cracking stage.
  - Set to 1 on the en accept.
  - Cleared on any written plaintext byte (k>=1) outside 0x20..0x7E.
  - Valid when rdy=1.
  - Reset value is 1.
- Undefined: the port and logic are absent. Timing is identical either way.

Decomposition:
- Package rc4_pkg:
  - typedef byte_t = logic[7:0].
  - prga_state_e enum (IDLE..DONE).
  - ASCII_MIN=8'h20, ASCII_MAX=8'h7E.
  - S_DEPTH=256.
- Sub-module rc4_ascii_chk (sticky range checker) is instantiated only under the macro. Otherwise the design is a single module.

Test Plan:
- S preloaded identity (S[x]=x), CT={01,00}, pulse en:
  - PT={01,02}.
  - S[1]=01, S[2]=02 unchanged.
  - rdy low for exactly 12 cycles.
- Identity S, CT={02,00,FF}:
  - PT={02,02,FA}.
  - S[2]=03, S[3]=02, all else identity.
  - rdy low for 21 cycles.
- CT={00}:
  - Only PT[0]=00 written; PT[1] untouched.
  - rdy low for 3 cycles.
- Start a len=5 run, assert rst_n=0 mid-byte 3 (in WR_I):
  - Immediately rdy=1, s_wren=0, pt_wren=0.
  - A new en then completes normally.
- en held high through an entire run and re-sampled: one run per rdy window; no second start while busy.
- With RC4_PRGA_ASCII_CHK_EN, identity S, CT={01,4A}:
  - PT[1]=48 ('H'), pt_ascii_ok=1.
- With RC4_PRGA_ASCII_CHK_EN, identity S, CT={01,00}:
  - PT[1]=02, pt_ascii_ok=0.
